// File: rtl/gf_poly_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : gf_poly_alu_if
// Purpose  : Handshake and operand bus for the GF(2^SIZE) polynomial ALU.
//            The master drives the request and operands. The slave returns
//            busy/done and the registered result.
// Signals  : start, mode[1:0], c[SIZE-1:0], flat_p/flat_q[FLAT_SIZE-1:0]
//            (master -> slave); busy, done, flat_z[FLAT_SIZE-1:0]
//            (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface gf_poly_alu_if #(
  parameter int SIZE      = 8,
  parameter int N         = 2,
  parameter int FLAT_SIZE = (N + 1) * SIZE
);
  logic                 start;
  logic [1:0]           mode;
  logic [SIZE-1:0]      c;
  logic [FLAT_SIZE-1:0] flat_p;
  logic [FLAT_SIZE-1:0] flat_q;
  logic                 busy;
  logic                 done;
  logic [FLAT_SIZE-1:0] flat_z;

  modport master (
    output start, mode, c, flat_p, flat_q,
    input  busy, done, flat_z
  );

  modport slave (
    input  start, mode, c, flat_p, flat_q,
    output busy, done, flat_z
  );
endinterface
`default_nettype wire

// File: rtl/gf_poly_alu.sv
`default_nettype none
// ============================================================================
// Module   : gf_poly_alu
// Purpose  : Sequential GF(2^SIZE) polynomial unit. It processes one
//            coefficient per clock through one shared field multiplier.
//            Modes: 0 ADD z=p+q, 1 SCALE_ADD z=p+c*q, 2 SCALE z=c*p,
//            3 EVAL z0=p(c) (Horner, highest coefficient first).
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous active-high reset
//            bus       - gf_poly_alu_if.slave (start/mode/c/flat_p/flat_q in,
//                        busy/done/flat_z out, all outputs registered)
// Revision : 1.0 - initial release
// ============================================================================
module gf_poly_alu #(
  parameter int            M         = 255,
  parameter int            SIZE      = $clog2(M),
  parameter int            N         = 2,
  parameter logic [SIZE:0] PRIM_POLY = 9'h11D,
  parameter int            FLAT_SIZE = (N + 1) * SIZE
) (
  input  logic           clk,
  input  logic           rst,
  gf_poly_alu_if.slave   bus
);

  localparam int IDX_W = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N);

  localparam logic [1:0] C_MODE_ADD       = 2'd0;
  localparam logic [1:0] C_MODE_SCALE_ADD = 2'd1;
  localparam logic [1:0] C_MODE_SCALE     = 2'd2;
  localparam logic [1:0] C_MODE_EVAL      = 2'd3;

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_RUN  = 1'b1;

  // Polynomial-basis shift-and-add multiply. The shifted copy of a is
  // reduced by PRIM_POLY every time it grows into bit SIZE.
  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
    logic [SIZE:0]   sh;
    logic [SIZE-1:0] res;
    sh  = {1'b0, a};
    res = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) res = res ^ sh[SIZE-1:0];
      sh = sh << 1;
      if (sh[SIZE]) sh = sh ^ PRIM_POLY;
    end
    return res;
  endfunction

  logic [0:0]           r_state;
  logic [1:0]           r_mode;
  logic [SIZE-1:0]      r_c;
  logic [FLAT_SIZE-1:0] r_p;
  logic [FLAT_SIZE-1:0] r_q;
  logic [FLAT_SIZE-1:0] r_w;
  logic [SIZE-1:0]      r_acc;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_busy;
  logic                 r_done;
  logic [FLAT_SIZE-1:0] r_flat_z;

  logic [SIZE-1:0]      w_p_arr [0:N];
  logic [SIZE-1:0]      w_q_arr [0:N];
  logic [SIZE-1:0]      w_p_coef;
  logic [SIZE-1:0]      w_q_coef;
  logic [SIZE-1:0]      w_mul_a;
  logic [SIZE-1:0]      w_mul_b;
  logic [SIZE-1:0]      w_mul;
  logic [SIZE-1:0]      w_coef_res;
  logic [SIZE-1:0]      w_acc_next;
  logic [FLAT_SIZE-1:0] w_w_next;
  logic [FLAT_SIZE-1:0] w_result;
  logic                 w_is_eval;
  logic                 w_last;

  generate
    for (genvar gi = 0; gi <= N; gi++) begin : g_unpack
      assign w_p_arr[gi] = r_p[gi*SIZE +: SIZE];
      assign w_q_arr[gi] = r_q[gi*SIZE +: SIZE];
    end
  endgenerate

  assign w_p_coef  = w_p_arr[r_idx];
  assign w_q_coef  = w_q_arr[r_idx];
  assign w_is_eval = (r_mode == C_MODE_EVAL);
  // EVAL walks the index down from N, the other modes walk up from 0.
  assign w_last    = w_is_eval ? (r_idx == '0) : (r_idx == C_IDX_LAST);

  // Route the single multiplier: c*q, c*p, or acc*c for Horner.
  always_comb begin
    w_mul_a = r_c;
    w_mul_b = w_q_coef;
    case (r_mode)
      C_MODE_SCALE: w_mul_b = w_p_coef;
      C_MODE_EVAL: begin
        w_mul_a = r_acc;
        w_mul_b = r_c;
      end
      default: ;
    endcase
  end

  assign w_mul      = gf_mul(w_mul_a, w_mul_b);
  assign w_acc_next = w_mul ^ w_p_coef;

  always_comb begin
    w_coef_res = w_p_coef ^ w_q_coef;
    case (r_mode)
      C_MODE_SCALE_ADD: w_coef_res = w_p_coef ^ w_mul;
      C_MODE_SCALE:     w_coef_res = w_mul;
      default: ;
    endcase
  end

  // The working result includes this step's coefficient, so the final
  // step can publish the complete result on the same edge.
  always_comb begin
    w_w_next = r_w;
    w_w_next[r_idx*SIZE +: SIZE] = w_coef_res;
  end

  assign w_result = w_is_eval ? FLAT_SIZE'(w_acc_next) : w_w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= C_IDLE;
      r_mode   <= '0;
      r_c      <= '0;
      r_p      <= '0;
      r_q      <= '0;
      r_w      <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_flat_z <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_c     <= bus.c;
            r_p     <= bus.flat_p;
            r_q     <= bus.flat_q;
            r_w     <= '0;
            r_acc   <= '0;
            r_idx   <= (bus.mode == C_MODE_EVAL) ? C_IDX_LAST : '0;
            r_busy  <= 1'b1;
            r_state <= C_RUN;
          end
        end
        C_RUN: begin
          if (w_is_eval) r_acc <= w_acc_next;
          else           r_w   <= w_w_next;
          if (w_last) begin
            r_flat_z <= w_result;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= C_IDLE;
          end else begin
            r_idx <= w_is_eval ? (r_idx - 1'b1) : (r_idx + 1'b1);
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.flat_z = r_flat_z;

endmodule
`default_nettype wire

// File: tb/tb_gf_poly_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_poly_alu
// Purpose  : Self-checking bench for gf_poly_alu. The reference model does
//            field multiplication through log/antilog tables and evaluates
//            polynomials as a direct sum of p[i]*c^i.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf_poly_alu;
  localparam int SIZE = 8;
  localparam int N    = 2;
  localparam int FW   = (N + 1) * SIZE;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int exp_t [0:254];
  int log_t [0:255];

  gf_poly_alu_if #(.SIZE(SIZE), .N(N)) bus ();

  gf_poly_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  function automatic logic [FW-1:0] model(input logic [1:0] m, input logic [7:0] cc,
                                          input logic [FW-1:0] p, input logic [FW-1:0] q);
    logic [FW-1:0] z;
    logic [7:0]    pw;
    logic [7:0]    sum;
    z = '0;
    if (m == 2'd3) begin
      pw  = 8'h01;
      sum = 8'h00;
      for (int i = 0; i <= N; i++) begin
        sum = sum ^ fmul(p[i*8 +: 8], pw);
        pw  = fmul(pw, cc);
      end
      z[7:0] = sum;
    end else begin
      for (int i = 0; i <= N; i++) begin
        case (m)
          2'd0:    z[i*8 +: 8] = p[i*8 +: 8] ^ q[i*8 +: 8];
          2'd1:    z[i*8 +: 8] = p[i*8 +: 8] ^ fmul(cc, q[i*8 +: 8]);
          default: z[i*8 +: 8] = fmul(cc, p[i*8 +: 8]);
        endcase
      end
    end
    return z;
  endfunction

  // Issue one operation and follow it to done. With dirty=1 a second start
  // with different operands is raised on the cycle after acceptance.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [7:0] cc,
                        input logic [FW-1:0] p, input logic [FW-1:0] q, input bit dirty);
    logic [FW-1:0] expz;
    int lat;
    int busy_cnt;
    expz = model(m, cc, p, q);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.c = cc; bus.flat_p = p; bus.flat_q = q;
    @(posedge clk); #1;
    check({tag, "_accept_done"}, 64'(bus.done), 64'd0);
    busy_cnt = bus.busy ? 1 : 0;
    // Operands wander during RUN; they must not matter.
    bus.start  = dirty;
    bus.mode   = 2'($urandom);
    bus.c      = 8'($urandom);
    bus.flat_p = FW'($urandom);
    bus.flat_q = FW'($urandom);
    lat = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = cyc;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 64'(lat != 0), 64'd1);
    if (lat != 0) begin
      check({tag, "_latency"}, 64'(lat), 64'(N + 1));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      check({tag, "_flat_z"}, 64'(bus.flat_z), 64'(expz));
    end
  endtask

  task automatic idle_hold(input string tag, input logic [FW-1:0] expz);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.c = 8'($urandom); bus.flat_p = FW'($urandom);
      @(posedge clk); #1;
      check({tag, "_done_low"}, 64'(bus.done), 64'd0);
      check({tag, "_hold"}, 64'(bus.flat_z), 64'(expz));
    end
  endtask

  initial begin : main
    int x;
    int dones;
    logic [1:0]    rm;
    logic [7:0]    rc;
    logic [FW-1:0] rp;
    logic [FW-1:0] rq;
    checks = 0;
    errors = 0;

    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x * 2;
      if (x >= 256) x = x ^ 'h11D;
    end
    log_t[0] = 0;

    bus.start = 1'b0; bus.mode = 2'd0; bus.c = 8'h00;
    bus.flat_p = '0; bus.flat_q = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_flat_z", 64'(bus.flat_z), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add", 2'd0, 8'h00, {8'h03, 8'h02, 8'h01}, {8'h01, 8'h02, 8'h03}, 1'b0);
    check("add_literal", 64'(bus.flat_z), 64'h020002);
    idle_hold("add", {8'h02, 8'h00, 8'h02});

    run_op("scale", 2'd2, 8'h02, {8'h00, 8'h01, 8'h80}, '0, 1'b0);
    check("scale_literal", 64'(bus.flat_z), 64'h00021D);
    run_op("scale_add", 2'd1, 8'h03, {8'h01, 8'h00, 8'h00}, {8'h00, 8'h01, 8'h03}, 1'b0);
    check("scale_add_literal", 64'(bus.flat_z), 64'h010305);
    run_op("eval_c2", 2'd3, 8'h02, {8'h01, 8'h01, 8'h01}, '0, 1'b0);
    check("eval_c2_literal", 64'(bus.flat_z), 64'h000007);
    run_op("eval_c0", 2'd3, 8'h00, {8'h01, 8'h01, 8'h01}, '0, 1'b0);
    run_op("scale_c1", 2'd2, 8'h01, {8'h5A, 8'hC3, 8'h7E}, '0, 1'b0);
    run_op("scale_c0", 2'd2, 8'h00, {8'h5A, 8'hC3, 8'h7E}, '0, 1'b0);

    // Restart while busy is ignored; restart while done is high is taken.
    run_op("hs_dirty", 2'd1, 8'h1F, {8'h12, 8'h34, 8'h56}, {8'h9A, 8'hBC, 8'hDE}, 1'b1);
    run_op("hs_on_done", 2'd3, 8'h35, {8'hA1, 8'hB2, 8'hC3}, '0, 1'b0);

    // Reset during the second step of an ADD.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'd0; bus.flat_p = {8'h11, 8'h22, 8'h33};
    bus.flat_q = {8'h44, 8'h55, 8'h66};
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    check("rst_mid_flat_z", 64'(bus.flat_z), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("rst_no_done", 64'(dones), 64'd0);
    run_op("after_rst", 2'd0, 8'h00, {8'h11, 8'h22, 8'h33}, {8'h44, 8'h55, 8'h66}, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rm = 2'($urandom);
      rc = 8'($urandom);
      rp = FW'($urandom);
      rq = FW'($urandom);
      run_op("rand", rm, rc, rp, rq, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
